// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive from a raw PWM with a programmable dead time.
// Defining PWM_DT_BREAK_EN adds an active-low break input and a latched fault output.
module pwm_deadtime #(
    parameter int unsigned DT_WIDTH = 16
) (
    input  logic                Clk50M,
    input  logic                Rst_n,
    input  logic                en,
    input  logic                i_pwm,
    input  logic [DT_WIDTH-1:0] dead_cycles,
`ifdef PWM_DT_BREAK_EN
    input  logic                i_break_n,
    output logic                o_fault,
`endif
    output logic                o_pwm_h,
    output logic                o_pwm_l,
    output logic                o_dt_active
);

`ifdef PWM_DT_BREAK_EN
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LOW   = 3'd1,
        ST_DT_R  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DT_F  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LOW   = 3'd1,
        ST_DT_R  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DT_F  = 3'd4
    } state_t;
`endif

    localparam logic [DT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [DT_WIDTH-1:0] CNT_ONE  = DT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                  pwm_q;
    logic                  pwm_h_q, pwm_l_q, dt_active_q;
    logic                  dt_zero_s;
    state_t                rise_state_s, fall_state_s;

    // A zero dead time skips the dead-time states entirely.
    assign dt_zero_s    = (dead_cycles == CNT_ZERO);
    assign rise_state_s = dt_zero_s ? ST_HIGH : ST_DT_R;
    assign fall_state_s = dt_zero_s ? ST_LOW  : ST_DT_F;

    // Next-state and dead-time counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PWM_DT_BREAK_EN
        if (!i_break_n) begin
            state_d = ST_BREAK;
            cnt_d   = CNT_ZERO;
        end else if (state_q == ST_BREAK) begin
            state_d = en ? ST_BREAK : ST_OFF;
            cnt_d   = CNT_ZERO;
        end else
`endif
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = pwm_q ? rise_state_s : fall_state_s;
                    cnt_d   = dead_cycles;
                end
                ST_LOW: begin
                    if (pwm_q) begin
                        state_d = rise_state_s;
                        cnt_d   = dead_cycles;
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = cnt_q;
                    end
                end
                ST_HIGH: begin
                    if (!pwm_q) begin
                        state_d = fall_state_s;
                        cnt_d   = dead_cycles;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = cnt_q;
                    end
                end
                // A pulse that reverts mid dead-time returns to the side that never switched off.
                ST_DT_R: begin
                    if (!pwm_q) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_DT_R;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                ST_DT_F: begin
                    if (pwm_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_DT_F;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter, input sample and registered gate outputs.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_OFF;
            cnt_q       <= CNT_ZERO;
            pwm_q       <= 1'b0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwm_q       <= i_pwm;
            pwm_h_q     <= (state_d == ST_HIGH);
            pwm_l_q     <= (state_d == ST_LOW);
            dt_active_q <= (state_d == ST_DT_R) || (state_d == ST_DT_F);
        end
    end

`ifdef PWM_DT_BREAK_EN
    logic fault_q;

    // Fault flag mirrors the BREAK state.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == ST_BREAK);
        end
    end

    assign o_fault = fault_q;
`endif

    assign o_pwm_h     = pwm_h_q;
    assign o_pwm_l     = pwm_l_q;
    assign o_dt_active = dt_active_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: vector table plus hand sequences for multi-cycle corners.
module tb_pwm_deadtime;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        pwm;
    logic [15:0] dead;
    logic        o_h, o_l, o_dt;
`ifdef PWM_DT_BREAK_EN
    logic        break_n;
    logic        fault;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic        pwm;
        logic [15:0] dead;
        logic        h;
        logic        l;
        logic        dt;
    } vec_t;

    vec_t vecs[$];

    pwm_deadtime #(.DT_WIDTH(16)) dut (
`ifdef PWM_DT_BREAK_EN
        .i_break_n  (break_n),
        .o_fault    (fault),
`endif
        .Clk50M     (clk),
        .Rst_n      (rst_n),
        .en         (en),
        .i_pwm      (pwm),
        .dead_cycles(dead),
        .o_pwm_h    (o_h),
        .o_pwm_l    (o_l),
        .o_dt_active(o_dt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check3(input string name, input logic h, input logic l, input logic dt);
        check({name, ".h"}, o_h, h);
        check({name, ".l"}, o_l, l);
        check({name, ".dt"}, o_dt, dt);
        check({name, ".overlap"}, o_h & o_l, 1'b0);
    endtask

    task automatic step(input logic e, input logic p, input logic [15:0] d);
        en   = e;
        pwm  = p;
        dead = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic p, input logic [15:0] d,
                       input logic h, input logic l, input logic dt);
        vec_t v;
        v.en = e; v.pwm = p; v.dead = d; v.h = h; v.l = l; v.dt = dt;
        vecs.push_back(v);
    endtask

    initial begin
        en    = 1'b0;
        pwm   = 1'b0;
        dead  = 16'd0;
        rst_n = 1'b1;
`ifdef PWM_DT_BREAK_EN
        break_n = 1'b1;
`endif

        //           en    pwm   D       h     l     dt
        add(1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 16'd9, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 16'd9, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 16'd9, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 16'd4, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'd4, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Reset state
        #2 rst_n = 1'b0;
        #3 check3("reset", 1'b0, 1'b0, 1'b0);
`ifdef PWM_DT_BREAK_EN
        check("reset.fault", fault, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].pwm, vecs[i].dead);
            check3($sformatf("vec%0d", i), vecs[i].h, vecs[i].l, vecs[i].dt);
        end

        // D=5, 50% duty, 200-cycle period, starting from LOW
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 200; j++) begin
                int  m;
                logic hi_half;
                hi_half = (j < 100);
                m = j % 100;
                step(1'b1, hi_half, 16'd5);
                if (m == 0)
                    check3($sformatf("duty_p%0d_j%0d", p, j), !hi_half, hi_half, 1'b0);
                else if (m <= 5)
                    check3($sformatf("duty_p%0d_j%0d", p, j), 1'b0, 1'b0, 1'b1);
                else
                    check3($sformatf("duty_p%0d_j%0d", p, j), hi_half, !hi_half, 1'b0);
            end
        end

        // D=10 with a 3-cycle high pulse: low side drops 3 cycles, high side never on
        step(1'b1, 1'b1, 16'd10); check3("short0", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'd10); check3("short1", 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'd10); check3("short2", 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'd10); check3("short3", 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'd10); check3("short4", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'd10); check3("short5", 1'b0, 1'b1, 1'b0);

        // Disable while HIGH, re-enable with pwm high and D=4
        step(1'b1, 1'b1, 16'd0); check3("en_pre0", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'd0); check3("en_pre1", 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'd4); check3("en_off", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 16'd4);
            check3($sformatf("en_dt%0d", k), 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b1, 16'd4); check3("en_high", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of DT_R, then dead time restarts from D
        step(1'b1, 1'b0, 16'd0); check3("rst_pre0", 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'd0); check3("rst_pre1", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'd6); check3("rst_pre2", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'd6); check3("rst_pre3", 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'd6); check3("rst_pre4", 1'b0, 1'b0, 1'b1);
        #4 rst_n = 1'b0;
        en = 1'b0;
        #1 check3("rst_async", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check3("rst_hold", 1'b0, 1'b0, 1'b0);
        #4 rst_n = 1'b1;
        step(1'b0, 1'b1, 16'd6); check3("rst_off", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 16'd6);
            check3($sformatf("rst_dt%0d", k), 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b1, 16'd6); check3("rst_high", 1'b1, 1'b0, 1'b0);

`ifdef PWM_DT_BREAK_EN
        // Break while HIGH latches the fault until en drops
        break_n = 1'b0;
        step(1'b1, 1'b1, 16'd6); check3("brk_enter", 1'b0, 1'b0, 1'b0);
        check("brk_enter.fault", fault, 1'b1);
        break_n = 1'b1;
        step(1'b1, 1'b1, 16'd6); check3("brk_hold", 1'b0, 1'b0, 1'b0);
        check("brk_hold.fault", fault, 1'b1);
        step(1'b0, 1'b1, 16'd6); check3("brk_clear", 1'b0, 1'b0, 1'b0);
        check("brk_clear.fault", fault, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
